// File: rtl/sevenseg_scan_ctrl_if.sv
// Update bus between the SevenSeg register slice (master) and the scan controller (slave).
// Inputs are sampled only at a frame boundary and must be held from upd_req until upd_ack.
interface sevenseg_scan_ctrl_if;
  logic [15:0] digit_val;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  brightness;
  logic        upd_req;
  logic        upd_ack;

  modport master (
    output digit_val,
    output dp_in,
    output digit_en,
    output brightness,
    output upd_req,
    input  upd_ack
  );

  modport slave (
    input  digit_val,
    input  dp_in,
    input  digit_en,
    input  brightness,
    input  upd_req,
    output upd_ack
  );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Four-digit seven-segment scan controller: per-slot blanking, 16-step PWM brightness,
// and a frame-synchronous shadow register load so a display update never tears.
module sevenseg_scan_ctrl #(
  parameter int CLK_DIV         = 100000,
  parameter int BLANK_CYC       = 16,
  parameter bit SEG_ACTIVE_LOW  = 1'b1,
  parameter bit GRID_ACTIVE_LOW = 1'b1
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  sevenseg_scan_ctrl_if.slave   upd_if,
  output logic [7:0]            hex_seg,
  output logic [3:0]            hex_grid,
  output logic                  frame_tick,
  output logic [1:0]            cur_digit
);

  localparam int              CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [7:0]      SEG_OFF   = SEG_ACTIVE_LOW  ? 8'hFF : 8'h00;
  localparam logic [3:0]      GRID_OFF  = GRID_ACTIVE_LOW ? 4'hF  : 4'h0;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] glyph;
    case (nib)
      4'h0:    glyph = 7'h3F;
      4'h1:    glyph = 7'h06;
      4'h2:    glyph = 7'h5B;
      4'h3:    glyph = 7'h4F;
      4'h4:    glyph = 7'h66;
      4'h5:    glyph = 7'h6D;
      4'h6:    glyph = 7'h7D;
      4'h7:    glyph = 7'h07;
      4'h8:    glyph = 7'h7F;
      4'h9:    glyph = 7'h6F;
      4'hA:    glyph = 7'h77;
      4'hB:    glyph = 7'h7C;
      4'hC:    glyph = 7'h39;
      4'hD:    glyph = 7'h5E;
      4'hE:    glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
    return glyph;
  endfunction

  function automatic logic [7:0] seg_pins(input logic [6:0] glyph, input logic dp);
    logic [7:0] lit_byte;
    lit_byte = {dp, glyph};
    return SEG_ACTIVE_LOW ? ~lit_byte : lit_byte;
  endfunction

  function automatic logic [3:0] grid_pins(input logic [1:0] digit);
    logic [3:0] onehot;
    onehot = 4'b0001 << digit;
    return GRID_ACTIVE_LOW ? ~onehot : onehot;
  endfunction

  // scan counters and update handshake
  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [3:0]       pwm_cnt_q, pwm_cnt_d;
  logic             pending_q, pending_d;

  // shadow copy of the display contents, swapped only at frame boundaries
  logic [15:0]      shadow_val_q, shadow_val_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [3:0]       shadow_en_q, shadow_en_d;
  logic [3:0]       shadow_bright_q, shadow_bright_d;

  // registered pins
  logic [7:0]       hex_seg_q, hex_seg_d;
  logic [3:0]       hex_grid_q, hex_grid_d;
  logic             frame_tick_q, frame_tick_d;
  logic             upd_ack_q, upd_ack_d;
  logic [1:0]       cur_digit_q, cur_digit_d;

  logic             slot_end;
  logic             in_blank;
  logic             boundary;
  logic             load;
  logic             lit;
  logic [3:0]       nibble;

  always_comb begin
    slot_end = (slot_cnt_q == SLOT_LAST);
    in_blank = (slot_cnt_q < BLANK_END);
    boundary = slot_end && (digit_q == 2'd3);
    // a request landing on the boundary cycle itself is folded into this load
    load     = boundary && (pending_q || upd_if.upd_req);

    slot_cnt_d = slot_end ? '0 : slot_cnt_q + CNT_W'(1);
    digit_d    = slot_end ? digit_q + 2'd1 : digit_q;
    pwm_cnt_d  = (slot_end || in_blank) ? 4'd0 : pwm_cnt_q + 4'd1;
    pending_d  = boundary ? 1'b0 : (pending_q || upd_if.upd_req);

    shadow_val_d    = shadow_val_q;
    shadow_dp_d     = shadow_dp_q;
    shadow_en_d     = shadow_en_q;
    shadow_bright_d = shadow_bright_q;
    if (load) begin
      shadow_val_d    = upd_if.digit_val;
      shadow_dp_d     = upd_if.dp_in;
      shadow_en_d     = upd_if.digit_en;
      shadow_bright_d = upd_if.brightness;
    end

    nibble = shadow_val_q[{digit_q, 2'b00} +: 4];
    lit    = !in_blank && shadow_en_q[digit_q] && (pwm_cnt_q <= shadow_bright_q);

    hex_seg_d    = lit ? seg_pins(hex_decode(nibble), shadow_dp_q[digit_q]) : SEG_OFF;
    hex_grid_d   = lit ? grid_pins(digit_q) : GRID_OFF;
    frame_tick_d = boundary;
    upd_ack_d    = load;
    cur_digit_d  = digit_q;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      slot_cnt_q      <= '0;
      digit_q         <= 2'd0;
      pwm_cnt_q       <= 4'd0;
      pending_q       <= 1'b0;
      shadow_val_q    <= 16'h0000;
      shadow_dp_q     <= 4'h0;
      shadow_en_q     <= 4'h0;
      shadow_bright_q <= 4'h0;
      hex_seg_q       <= SEG_OFF;
      hex_grid_q      <= GRID_OFF;
      frame_tick_q    <= 1'b0;
      upd_ack_q       <= 1'b0;
      cur_digit_q     <= 2'd0;
    end else begin
      slot_cnt_q      <= slot_cnt_d;
      digit_q         <= digit_d;
      pwm_cnt_q       <= pwm_cnt_d;
      pending_q       <= pending_d;
      shadow_val_q    <= shadow_val_d;
      shadow_dp_q     <= shadow_dp_d;
      shadow_en_q     <= shadow_en_d;
      shadow_bright_q <= shadow_bright_d;
      hex_seg_q       <= hex_seg_d;
      hex_grid_q      <= hex_grid_d;
      frame_tick_q    <= frame_tick_d;
      upd_ack_q       <= upd_ack_d;
      cur_digit_q     <= cur_digit_d;
    end
  end

  assign hex_seg        = hex_seg_q;
  assign hex_grid       = hex_grid_q;
  assign frame_tick     = frame_tick_q;
  assign cur_digit      = cur_digit_q;
  assign upd_if.upd_ack = upd_ack_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: cycle scoreboard on every pin plus table-driven
// per-frame display checks and hand-written update/reset corner sequences.
module tb_sevenseg_scan_ctrl;
  localparam int CLK_DIV   = 64;
  localparam int BLANK_CYC = 8;
  localparam int FRAME     = 4 * CLK_DIV;

  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       ACLK = 1'b0;
  logic       ARESET = 1'b1;
  logic [7:0] hex_seg;
  logic [3:0] hex_grid;
  logic       frame_tick;
  logic [1:0] cur_digit;

  sevenseg_scan_ctrl_if u_if ();

  sevenseg_scan_ctrl #(
    .CLK_DIV        (CLK_DIV),
    .BLANK_CYC      (BLANK_CYC),
    .SEG_ACTIVE_LOW (1'b1),
    .GRID_ACTIVE_LOW(1'b1)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .upd_if    (u_if),
    .hex_seg   (hex_seg),
    .hex_grid  (hex_grid),
    .frame_tick(frame_tick),
    .cur_digit (cur_digit)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_pass   = 0;
  int ack_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- cycle scoreboard ----------------
  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] grid;
    logic       tick;
    logic       ack;
    logic [1:0] cur;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        m_e;
  exp_t        chk_e;
  int          m_k;
  int          m_within;
  int          m_dig;
  int          m_pwm;
  logic        m_on;
  logic        m_bnd;
  logic        m_pend;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_en, m_br;

  always @(posedge ACLK) begin
    if (ARESET) begin
      m_k = 0; m_pend = 1'b0;
      m_val = 16'h0; m_dp = 4'h0; m_en = 4'h0; m_br = 4'h0;
      m_e.seg = 8'hFF; m_e.grid = 4'hF; m_e.tick = 1'b0; m_e.ack = 1'b0; m_e.cur = 2'd0;
    end else begin
      m_within = m_k % CLK_DIV;
      m_dig    = (m_k / CLK_DIV) % 4;
      m_pwm    = (m_within < BLANK_CYC) ? 0 : (m_within - BLANK_CYC) % 16;
      m_on     = (m_within >= BLANK_CYC) && m_en[m_dig] && (m_pwm <= int'(m_br));
      m_bnd    = (m_k % FRAME) == FRAME - 1;
      m_e.seg  = m_on ? ~{m_dp[m_dig], GLYPH[m_val[4*m_dig +: 4]]} : 8'hFF;
      m_e.grid = m_on ? ~(4'b0001 << m_dig) : 4'hF;
      m_e.tick = m_bnd;
      m_e.ack  = m_bnd && (m_pend || u_if.upd_req);
      m_e.cur  = 2'(m_dig);
      if (m_e.ack) begin
        m_val = u_if.digit_val; m_dp = u_if.dp_in; m_en = u_if.digit_en; m_br = u_if.brightness;
      end
      m_pend = m_bnd ? 1'b0 : (m_pend || u_if.upd_req);
      m_k    = (m_k + 1) % FRAME;
    end
    sb_q.push_back(m_e);
  end

  always @(negedge ACLK) begin
    if (u_if.upd_ack === 1'b1) ack_cnt++;
    if (sb_q.size() != 0) begin
      chk_e = sb_q.pop_front();
      n_checks++;
      if (hex_seg === chk_e.seg && hex_grid === chk_e.grid && frame_tick === chk_e.tick &&
          u_if.upd_ack === chk_e.ack && cur_digit === chk_e.cur && $onehot0(~hex_grid))
        n_pass++;
      else
        $display("FAIL pins t=%0t seg %h/%h grid %b/%b tick %b/%b ack %b/%b cur %0d/%0d (got/expected)",
                 $time, hex_seg, chk_e.seg, hex_grid, chk_e.grid, frame_tick, chk_e.tick,
                 u_if.upd_ack, chk_e.ack, cur_digit, chk_e.cur);
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse_req();
    u_if.upd_req = 1'b1;
    @(negedge ACLK);
    u_if.upd_req = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(negedge ACLK);
      seen = u_if.upd_ack;
    end
    check({name, "_ack_seen"}, 32'(seen), 32'd1);
  endtask

  // Observes one full frame starting right after the upd_ack cycle.
  task automatic observe_frame(input string name, input logic [3:0][7:0] exp_seg,
                               input logic [3:0][7:0] exp_cnt);
    int         cnt [4];
    logic [7:0] seen [4];
    int         d;
    int         sel_err;
    int         blank_err;
    int         seg_err;
    sel_err = 0; blank_err = 0; seg_err = 0;
    for (int k = 0; k < 4; k++) begin cnt[k] = 0; seen[k] = 8'h00; end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge ACLK);
      d = i / CLK_DIV;
      if ((i % CLK_DIV) < BLANK_CYC && hex_grid !== 4'hF) blank_err++;
      if (hex_grid !== 4'hF) begin
        cnt[d]++;
        if (hex_grid !== ~(4'b0001 << d)) sel_err++;
        if (cnt[d] == 1) seen[d] = hex_seg;
        else if (hex_seg !== seen[d]) seg_err++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_on_cycles_d%0d", name, k), 32'(cnt[k]), 32'(exp_cnt[k]));
      if (exp_cnt[k] != 8'd0)
        check($sformatf("%s_seg_d%0d", name, k), 32'(seen[k]), 32'(exp_seg[k]));
    end
    check({name, "_grid_select"}, 32'(sel_err), 32'd0);
    check({name, "_blank_dark"}, 32'(blank_err), 32'd0);
    check({name, "_seg_steady"}, 32'(seg_err), 32'd0);
  endtask

  typedef struct packed {
    logic [15:0]      val;
    logic [3:0]       dp;
    logic [3:0]       en;
    logic [3:0]       br;
    logic [3:0][7:0]  seg;
    logic [3:0][7:0]  cnt;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int ticks;
    int tick_first;
    int tick_second;
    int lit_cnt;
    int a0;
    logic found;

    vecs[0] = '{val:16'h4321, dp:4'b0001, en:4'hF,    br:4'd15,
                seg:{8'h99, 8'hB0, 8'hA4, 8'h79}, cnt:{8'd56, 8'd56, 8'd56, 8'd56}};
    vecs[1] = '{val:16'h8E0B, dp:4'b1010, en:4'b1011, br:4'd3,
                seg:{8'h00, 8'h86, 8'h40, 8'h83}, cnt:{8'd16, 8'd0, 8'd16, 8'd16}};
    vecs[2] = '{val:16'h9D6A, dp:4'b0000, en:4'b0101, br:4'd0,
                seg:{8'h90, 8'hA1, 8'h82, 8'h88}, cnt:{8'd0, 8'd4, 8'd0, 8'd4}};
    vecs[3] = '{val:16'h75C2, dp:4'b1111, en:4'hF,    br:4'd7,
                seg:{8'h78, 8'h12, 8'h46, 8'h24}, cnt:{8'd32, 8'd32, 8'd32, 8'd32}};

    u_if.digit_val = 16'h0; u_if.dp_in = 4'h0; u_if.digit_en = 4'h0;
    u_if.brightness = 4'h0; u_if.upd_req = 1'b0;

    // reset held three cycles
    repeat (3) @(negedge ACLK);
    check("rst_seg",   32'(hex_seg),      32'hFF);
    check("rst_grid",  32'(hex_grid),     32'hF);
    check("rst_tick",  32'(frame_tick),   32'd0);
    check("rst_ack",   32'(u_if.upd_ack), 32'd0);
    check("rst_cur",   32'(cur_digit),    32'd0);
    ARESET = 1'b0;

    // two dark frames, no update
    ticks = 0; tick_first = -1; tick_second = -1; lit_cnt = 0; a0 = ack_cnt;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge ACLK);
      if (frame_tick) begin
        ticks++;
        if (tick_first < 0) tick_first = i; else tick_second = i;
      end
      if (hex_grid !== 4'hF || hex_seg !== 8'hFF) lit_cnt++;
    end
    check("idle_tick_count",  32'(ticks),       32'd2);
    check("idle_tick_first",  32'(tick_first),  32'(FRAME - 1));
    check("idle_tick_period", 32'(tick_second - tick_first), 32'(FRAME));
    check("idle_dark",        32'(lit_cnt),     32'd0);
    check("idle_no_ack",      32'(ack_cnt - a0), 32'd0);

    // table-driven display updates
    for (int r = 0; r < 4; r++) begin
      u_if.digit_val  = vecs[r].val;
      u_if.dp_in      = vecs[r].dp;
      u_if.digit_en   = vecs[r].en;
      u_if.brightness = vecs[r].br;
      a0 = ack_cnt;
      pulse_req();
      wait_ack($sformatf("vec%0d", r));
      observe_frame($sformatf("vec%0d", r), vecs[r].seg, vecs[r].cnt);
      check($sformatf("vec%0d_single_ack", r), 32'(ack_cnt - a0), 32'd1);
    end

    // merged requests: first during digit 1, second after changing the value
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge ACLK);
      found = (cur_digit == 2'd1);
    end
    check("merge_reach_d1", 32'(found), 32'd1);
    a0 = ack_cnt;
    u_if.dp_in = 4'h0; u_if.digit_en = 4'hF; u_if.brightness = 4'd15;
    pulse_req();
    repeat (5) @(negedge ACLK);
    u_if.digit_val = 16'hFFFF;
    pulse_req();
    wait_ack("merge");
    observe_frame("merge", {8'h8E, 8'h8E, 8'h8E, 8'h8E}, {8'd56, 8'd56, 8'd56, 8'd56});
    check("merge_single_ack", 32'(ack_cnt - a0), 32'd1);

    // reset with an update pending, during digit 2 ON phase
    a0 = ack_cnt;
    u_if.digit_val = 16'h1234;
    pulse_req();
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge ACLK);
      found = (cur_digit == 2'd2) && (hex_grid !== 4'hF);
    end
    check("rst_mid_reach_d2", 32'(found), 32'd1);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("rst_mid_grid", 32'(hex_grid),  32'hF);
    check("rst_mid_cur",  32'(cur_digit), 32'd0);
    check("rst_mid_seg",  32'(hex_seg),   32'hFF);
    ARESET = 1'b0;
    lit_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge ACLK);
      if (hex_grid !== 4'hF) lit_cnt++;
    end
    check("rst_mid_dark",   32'(lit_cnt),      32'd0);
    check("rst_mid_no_ack", 32'(ack_cnt - a0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Scan controller for the Urbana 4-digit seven-segment display. It time-multiplexes four digits onto shared segment lines and applies blanking between digits and PWM brightness. Display contents are double-buffered so that updates take effect only at frame boundaries, which prevents tearing. It sits between the AXI-Lite register slice of the SevenSeg IP, which drives its inputs, and the board pins.

Parameters:
CLK_DIV, 100000, ACLK cycles per digit slot (1 ms at 100 MHz); must exceed BLANK_CYC+16.
BLANK_CYC, 16, cycles at the start of each slot with all grids off (anti-ghosting).
SEG_ACTIVE_LOW, 1, 1 = segment pins active-low.
GRID_ACTIVE_LOW, 1, 1 = grid (digit select) pins active-low.

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous, active-high reset
digit_val  in  16  hex nibble per digit; digit n = [4n+3:4n]
dp_in  in  4  decimal point per digit
digit_en  in  4  per-digit enable; disabled digit stays dark
brightness  in  4  duty level 0..15
upd_req  in  1  single-cycle request to load the inputs above into the shadow registers
upd_ack  out  1  single-cycle pulse when the shadow load is done
hex_seg  out  8  [6:0]=g..a, [7]=dp
hex_grid  out  4  digit select, one-hot when active
frame_tick  out  1  single-cycle pulse at each frame end
cur_digit  out  2  digit currently scanned

Behaviour:
- Reset (synchronous, active-high):
  - Slot counter, PWM counter and cur_digit go to 0; the pending flag clears.
  - Shadow registers clear (val=0, dp=0, en=0, brightness=0).
  - hex_seg = all inactive (8'hFF when active-low); hex_grid = all inactive (4'hF).
  - upd_ack = 0, frame_tick = 0.
  - The display stays dark until the first update.
- Slot counter runs 0..CLK_DIV-1 every cycle.
  - BLANK phase: slot_cnt < BLANK_CYC. All grids and all segments inactive.
  - ON phase: the remainder of the slot. The 4-bit PWM counter increments each ON cycle and is cleared on entry to BLANK.
- Grid for cur_digit is active only when: ON phase, shadow_en[cur_digit]=1, and pwm_cnt <= shadow_brightness.
  - brightness=15 gives full on; brightness=0 gives 1/16 duty.
  - Segments are driven with the decoded digit under the same condition, otherwise inactive.
- Slot end (slot_cnt = CLK_DIV-1): cur_digit increments mod 4.
- Frame boundary = slot end while cur_digit = 3. On that cycle:
  - frame_tick pulses (registered, visible the next cycle).
  - If pending = 1: digit_val, dp_in, digit_en and brightness are sampled into the shadow registers that cycle, pending clears, and upd_ack pulses the next cycle.
- upd_req:
  - Sets pending.
  - upd_req while already pending is merged: one load, one ack.
  - upd_req on the boundary cycle itself is served at that boundary.
  - Inputs must be held stable from upd_req until upd_ack.
- Decoder: standard hex, active-high gfedcba patterns: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71. Bit 7 = dp. The byte is inverted when SEG_ACTIVE_LOW=1.
- Output timing: all outputs are registered, with 1-cycle latency from counter state to pins.
- Grid exclusivity: at most one grid is active in any cycle. Grids never change without at least BLANK_CYC dark cycles in between.
- ARESET mid-frame: on the next edge, outputs go inactive and cur_digit=0. Any pending update is dropped with no ack.

Test Plan (CLK_DIV=64, BLANK_CYC=8, active-low defaults):
1. Hold ARESET 3 cycles, then run 2 frames with no upd_req -> hex_seg=8'hFF and hex_grid=4'hF throughout; upd_ack never asserts; frame_tick pulses every 256 cycles.
2. Apply digit_val=16'h4321, dp_in=4'b0001, digit_en=4'hF, brightness=15, then pulse upd_req -> exactly one upd_ack, one cycle after the next frame boundary. Following frame:
   - digit 0 slot: hex_grid=4'b1110, hex_seg=8'h79.
   - digit 3 slot: hex_grid=4'b0111, hex_seg=8'h99.
   - grid continuously active for all 56 ON cycles of each slot.
3. Blanking/exclusivity check over 4 frames -> the first 8 cycles of every slot have hex_grid=4'hF; $onehot0(~hex_grid) holds every cycle.
4. brightness=3 loaded via update -> in every 16-cycle PWM window of an ON phase the grid is active exactly 4 cycles; digit_en=4'b1011 -> digit 2 grid never active.
5. Pulse upd_req during the digit 1 slot, change digit_val to 16'hFFFF, pulse upd_req again before ack -> display shows old values through digit 3; a single upd_ack; the next frame shows F (8'h8E) on all digits.
6. Pulse upd_req, then assert ARESET during the digit 2 ON phase before the boundary -> next cycle hex_grid=4'hF and cur_digit=0; no upd_ack; the display stays dark.
